memory_neuron_array: RTL and testbench

Twenty-entry shape-code store that sits directly downstream of the inter-neuron and captures every `{flat, addr}` shape code it writes. It also provides a sequential recall engine. Given a query flatness value, the engine scans the stored entries in index order and reports the first entry whose flatness field matches. Recall results go to the output/display stage of BRAIN:M.

---
 rtl/memory_neuron_array_if.sv | 28 ++
 rtl/memory_neuron_array.sv | 118 +++++++++++
 tb/tb_memory_neuron_array.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/memory_neuron_array_if.sv
// Write port, recall request and recall result bundle for memory_neuron_array.
// The inter-neuron/bench side uses master; the store uses slave.
interface memory_neuron_array_if #(
  parameter int FW = 7,
  parameter int AW = 5
);
  logic               wE;
  logic [AW-1:0]      wAddr;
  logic [FW+AW-1:0]   shape_code;
  logic               query_start;
  logic [FW-1:0]      query_flat;
  logic               busy;
  logic               done;
  logic               match_found;
  logic [AW-1:0]      match_addr;
  logic [FW+AW-1:0]   match_code;
  logic [AW-1:0]      count;

  modport master (
    output wE, wAddr, shape_code, query_start, query_flat,
    input  busy, done, match_found, match_addr, match_code, count
  );

  modport slave (
    input  wE, wAddr, shape_code, query_start, query_flat,
    output busy, done, match_found, match_addr, match_code, count
  );
endinterface

// File: rtl/memory_neuron_array.sv
// Shape-code store with a first-match recall engine scanning entries in index order.
// state | meaning
// IDLE  | waiting for query_start
// SCAN  | comparing entry idx against the latched query flatness
// DONE  | one-cycle done pulse; results already registered
module memory_neuron_array #(
  parameter int DEPTH = 20,
  parameter int FW    = 7,
  parameter int AW    = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  memory_neuron_array_if.slave bus
);
  localparam int CW = FW + AW;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [AW-1:0]   count;
  logic [AW-1:0]   idx;
  logic [FW-1:0]   q_reg;
  logic            match_found;
  logic [AW-1:0]   match_addr;
  logic [CW-1:0]   match_code;

  logic wr_ok, hit, last;
  logic start, step, ld_hit, ld_miss;

  assign wr_ok = bus.wE && (bus.wAddr < AW'(DEPTH));
  // Compare reads the registered contents, so a same-edge write is not seen yet.
  assign hit   = valid[idx] && (mem[idx][CW-1:AW] == q_reg);
  assign last  = (idx == AW'(DEPTH - 1));

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    step      = 1'b0;
    ld_hit    = 1'b0;
    ld_miss   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.query_start) begin
          state_nxt = SCAN;
          start     = 1'b1;
        end
      end
      SCAN: begin
        if (hit) begin
          state_nxt = DONE;
          ld_hit    = 1'b1;
        end else if (last) begin
          state_nxt = DONE;
          ld_miss   = 1'b1;
        end else begin
          step = 1'b1;
        end
      end
      DONE: begin
        // The edge closing DONE may already launch the next recall.
        if (bus.query_start) begin
          state_nxt = SCAN;
          start     = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      valid       <= '0;
      count       <= '0;
      idx         <= '0;
      q_reg       <= '0;
      match_found <= 1'b0;
      match_addr  <= '0;
      match_code  <= '0;
    end else begin
      state <= state_nxt;
      if (wr_ok) begin
        valid[bus.wAddr] <= 1'b1;
        if (!valid[bus.wAddr]) count <= count + 1'b1;
      end
      if (start) begin
        q_reg <= bus.query_flat;
        idx   <= '0;
      end
      if (step) idx <= idx + 1'b1;
      if (ld_hit) begin
        match_found <= 1'b1;
        match_addr  <= idx;
        match_code  <= mem[idx];
      end
      if (ld_miss) begin
        match_found <= 1'b0;
        match_addr  <= '0;
        match_code  <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[bus.wAddr] <= bus.shape_code;
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
  assign bus.match_found = match_found;
  assign bus.match_addr  = match_addr;
  assign bus.match_code  = match_code;
  assign bus.count       = count;
endmodule

// File: tb/tb_memory_neuron_array.sv
// Self-checking bench for memory_neuron_array: directed scenarios plus randomized
// write/recall rounds checked against an array-based first-match model.
module tb_memory_neuron_array;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;

  memory_neuron_array_if #(.FW(7), .AW(5)) bus ();

  memory_neuron_array #(.DEPTH(20), .FW(7), .AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: plain arrays, first-match by linear search.
  logic [11:0] m_mem [20];
  bit          m_valid [20];
  int          m_count = 0;

  function automatic void model_reset();
    for (int i = 0; i < 20; i++) m_valid[i] = 1'b0;
    m_count = 0;
  endfunction

  function automatic void model_write(input int a, input logic [11:0] c);
    if (a < 20) begin
      if (!m_valid[a]) m_count++;
      m_valid[a] = 1'b1;
      m_mem[a]   = c;
    end
  endfunction

  function automatic int model_find(input logic [6:0] q);
    for (int i = 0; i < 20; i++)
      if (m_valid[i] && m_mem[i][11:5] == q) return i;
    return -1;
  endfunction

  task automatic drive_write(input int a, input logic [6:0] flat);
    logic [11:0] c;
    c = {flat, a[4:0]};
    bus.wE = 1'b1; bus.wAddr = a[4:0]; bus.shape_code = c;
    @(posedge clk); #1;
    bus.wE = 1'b0;
    model_write(a, c);
  endtask

  // Issue a recall; optional write / reset / extra query_start at edge N after the start edge.
  task automatic run_query(input logic [6:0] qf, input int w_edge, input int w_addr,
                           input logic [11:0] w_code, input int rst_edge, input int qs_edge,
                           input logic [6:0] qs_flat, output int lat, output int ndone,
                           output int nbusy);
    bus.query_start = 1'b1; bus.query_flat = qf;
    @(posedge clk); #1;
    bus.query_start = 1'b0;
    lat = -1; ndone = 0; nbusy = bus.busy ? 1 : 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == w_edge) begin bus.wE = 1'b1; bus.wAddr = w_addr[4:0]; bus.shape_code = w_code; end
      if (c == rst_edge) rst = 1'b1;
      if (c == qs_edge) begin bus.query_start = 1'b1; bus.query_flat = qs_flat; end
      @(posedge clk); #1;
      if (c == w_edge) begin bus.wE = 1'b0; model_write(w_addr, w_code); end
      if (c == rst_edge) begin rst = 1'b0; model_reset(); end
      if (c == qs_edge) bus.query_start = 1'b0;
      if (bus.done) begin ndone++; if (lat < 0) lat = c; end
      if (!bus.busy) break;
      nbusy++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_cmp++; if (bus.match_found !== 1'b0) begin n_err++; $display("FAIL reset_found: got %b want 0", bus.match_found); end
    n_cmp++; if (bus.match_addr !== 5'd0) begin n_err++; $display("FAIL reset_addr: got %0d want 0", bus.match_addr); end
    n_cmp++; if (bus.match_code !== 12'd0) begin n_err++; $display("FAIL reset_code: got %h want 000", bus.match_code); end
    n_cmp++; if (bus.count !== 5'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    int lat, nd, nb;
    drive_write(0, 7'd100);
    drive_write(1, 7'd95);
    drive_write(2, 7'd90);
    n_cmp++; if (bus.count !== 5'd3) begin n_err++; $display("FAIL basic_count: got %0d want 3", bus.count); end
    run_query(7'd95, 0, 0, 12'd0, 0, 0, 7'd0, lat, nd, nb);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL basic_latency: got %0d want 2", lat); end
    n_cmp++; if (nb !== 3) begin n_err++; $display("FAIL basic_busy_cycles: got %0d want 3", nb); end
    n_cmp++; if (bus.match_found !== 1'b1) begin n_err++; $display("FAIL basic_found: got %b want 1", bus.match_found); end
    n_cmp++; if (bus.match_addr !== 5'd1) begin n_err++; $display("FAIL basic_addr: got %0d want 1", bus.match_addr); end
    n_cmp++; if (bus.match_code !== 12'hBE1) begin n_err++; $display("FAIL basic_code: got %h want be1", bus.match_code); end
  endtask

  task automatic test_miss();
    int lat, nd, nb;
    run_query(7'd55, 0, 0, 12'd0, 0, 0, 7'd0, lat, nd, nb);
    n_cmp++; if (nb !== 21) begin n_err++; $display("FAIL miss_busy_cycles: got %0d want 21", nb); end
    n_cmp++; if (nd !== 1) begin n_err++; $display("FAIL miss_done_pulses: got %0d want 1", nd); end
    n_cmp++; if (lat !== 20) begin n_err++; $display("FAIL miss_latency: got %0d want 20", lat); end
    n_cmp++; if (bus.match_found !== 1'b0) begin n_err++; $display("FAIL miss_found: got %b want 0", bus.match_found); end
    n_cmp++; if (bus.match_addr !== 5'd0) begin n_err++; $display("FAIL miss_addr: got %0d want 0", bus.match_addr); end
    n_cmp++; if (bus.match_code !== 12'd0) begin n_err++; $display("FAIL miss_code: got %h want 000", bus.match_code); end
  endtask

  task automatic test_duplicate();
    int lat, nd, nb;
    drive_write(5, 7'd90);
    run_query(7'd90, 0, 0, 12'd0, 0, 0, 7'd0, lat, nd, nb);
    n_cmp++; if (bus.match_addr !== 5'd2) begin n_err++; $display("FAIL dup_first_addr: got %0d want 2", bus.match_addr); end
    drive_write(2, 7'd80);
    n_cmp++; if (bus.count !== 5'd4) begin n_err++; $display("FAIL dup_overwrite_count: got %0d want 4", bus.count); end
    run_query(7'd90, 0, 0, 12'd0, 0, 0, 7'd0, lat, nd, nb);
    n_cmp++; if (bus.match_addr !== 5'd5) begin n_err++; $display("FAIL dup_second_addr: got %0d want 5", bus.match_addr); end
    n_cmp++; if (lat !== 6) begin n_err++; $display("FAIL dup_second_latency: got %0d want 6", lat); end
  endtask

  task automatic test_out_of_range();
    int lat, nd, nb;
    drive_write(25, 7'd77);
    drive_write(31, 7'd77);
    n_cmp++; if (bus.count !== 5'(m_count)) begin n_err++; $display("FAIL oor_count: got %0d want %0d", bus.count, m_count); end
    run_query(7'd77, 0, 0, 12'd0, 0, 0, 7'd0, lat, nd, nb);
    n_cmp++; if (bus.match_found !== 1'b0) begin n_err++; $display("FAIL oor_found: got %b want 0", bus.match_found); end
  endtask

  task automatic test_ignore_start();
    int lat, nd, nb;
    run_query(7'd33, 0, 0, 12'd0, 0, 5, 7'd100, lat, nd, nb);
    n_cmp++; if (nd !== 1) begin n_err++; $display("FAIL ignore_done_pulses: got %0d want 1", nd); end
    n_cmp++; if (lat !== 20) begin n_err++; $display("FAIL ignore_latency: got %0d want 20", lat); end
    n_cmp++; if (bus.match_found !== 1'b0) begin n_err++; $display("FAIL ignore_found: got %b want 0", bus.match_found); end
  endtask

  task automatic test_same_edge_write();
    int lat, nd, nb;
    // Index 3 is compared at edge 4; a write landing on that edge must not be seen.
    run_query(7'd60, 4, 3, {7'd60, 5'd3}, 0, 0, 7'd0, lat, nd, nb);
    n_cmp++; if (bus.match_found !== 1'b0) begin n_err++; $display("FAIL same_edge_found: got %b want 0", bus.match_found); end
    n_cmp++; if (lat !== 20) begin n_err++; $display("FAIL same_edge_latency: got %0d want 20", lat); end
    run_query(7'd60, 0, 0, 12'd0, 0, 0, 7'd0, lat, nd, nb);
    n_cmp++; if (bus.match_addr !== 5'd3 || lat !== 4) begin n_err++; $display("FAIL same_edge_later_hit: got addr %0d lat %0d want addr 3 lat 4", bus.match_addr, lat); end
    run_query(7'd61, 3, 10, {7'd61, 5'd10}, 0, 0, 7'd0, lat, nd, nb);
    n_cmp++; if (bus.match_found !== 1'b1 || bus.match_addr !== 5'd10) begin n_err++; $display("FAIL ahead_write_hit: got found %b addr %0d want 1 10", bus.match_found, bus.match_addr); end
    n_cmp++; if (lat !== 11) begin n_err++; $display("FAIL ahead_write_latency: got %0d want 11", lat); end
  endtask

  task automatic test_back_to_back();
    bit seen;
    int lat;
    bus.query_start = 1'b1; bus.query_flat = 7'd95;
    @(posedge clk); #1;
    bus.query_start = 1'b0;
    seen = 1'b0;
    for (int c = 1; c <= 30 && !seen; c++) begin
      @(posedge clk); #1;
      if (bus.done) seen = 1'b1;
    end
    n_cmp++; if (!seen || bus.match_addr !== 5'd1) begin n_err++; $display("FAIL b2b_first: got done %b addr %0d want 1 1", seen, bus.match_addr); end
    bus.query_start = 1'b1; bus.query_flat = 7'd90;
    @(posedge clk); #1;
    bus.query_start = 1'b0;
    n_cmp++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin n_err++; $display("FAIL b2b_accept: got busy %b done %b want 1 0", bus.busy, bus.done); end
    lat = -1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (bus.done) begin lat = c; break; end
    end
    n_cmp++; if (lat !== 6) begin n_err++; $display("FAIL b2b_latency: got %0d want 6", lat); end
    n_cmp++; if (bus.match_addr !== 5'd5 || bus.match_code !== {7'd90, 5'd5}) begin n_err++; $display("FAIL b2b_second: got addr %0d code %h want 5 %h", bus.match_addr, bus.match_code, {7'd90, 5'd5}); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_scan();
    int lat, nd, nb;
    run_query(7'd90, 0, 0, 12'd0, 5, 0, 7'd0, lat, nd, nb);
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.count !== 5'd0) begin n_err++; $display("FAIL rst_mid_count: got %0d want 0", bus.count); end
    n_cmp++; if (nd !== 0) begin n_err++; $display("FAIL rst_mid_done_pulses: got %0d want 0", nd); end
    n_cmp++; if (bus.match_found !== 1'b0 || bus.match_addr !== 5'd0 || bus.match_code !== 12'd0) begin n_err++; $display("FAIL rst_mid_outputs: got %b %0d %h want 0 0 000", bus.match_found, bus.match_addr, bus.match_code); end
    run_query(7'd90, 0, 0, 12'd0, 0, 0, 7'd0, lat, nd, nb);
    n_cmp++; if (bus.match_found !== 1'b0 || lat !== 20) begin n_err++; $display("FAIL rst_mid_requery: got found %b lat %0d want 0 20", bus.match_found, lat); end
  endtask

  task automatic test_random();
    int lat, nd, nb, k, nw;
    logic [6:0] q;
    for (int r = 0; r < 25; r++) begin
      nw = $urandom_range(1, 3);
      for (int w = 0; w < nw; w++) drive_write($urandom_range(0, 24), 7'($urandom_range(0, 7)));
      q = 7'($urandom_range(0, 9));
      k = model_find(q);
      run_query(q, 0, 0, 12'd0, 0, 0, 7'd0, lat, nd, nb);
      n_cmp++; if (lat !== ((k >= 0) ? k + 1 : 20) || nd !== 1) begin n_err++; $display("FAIL rand_latency r%0d: got lat %0d pulses %0d want lat %0d pulses 1", r, lat, nd, (k >= 0) ? k + 1 : 20); end
      n_cmp++; if (bus.match_found !== (k >= 0)) begin n_err++; $display("FAIL rand_found r%0d: got %b want %b", r, bus.match_found, k >= 0); end
      n_cmp++; if (bus.match_addr !== ((k >= 0) ? 5'(k) : 5'd0) || bus.match_code !== ((k >= 0) ? m_mem[k] : 12'd0)) begin n_err++; $display("FAIL rand_result r%0d: got addr %0d code %h want addr %0d", r, bus.match_addr, bus.match_code, (k >= 0) ? k : 0); end
      n_cmp++; if (bus.count !== 5'(m_count)) begin n_err++; $display("FAIL rand_count r%0d: got %0d want %0d", r, bus.count, m_count); end
    end
  endtask

  initial begin
    bus.wE = 1'b0; bus.wAddr = '0; bus.shape_code = '0;
    bus.query_start = 1'b0; bus.query_flat = '0;
    test_reset();
    test_basic();
    test_miss();
    test_duplicate();
    test_out_of_range();
    test_ignore_start();
    test_same_edge_write();
    test_back_to_back();
    test_reset_mid_scan();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
